// File: rtl/dac_spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_pkg
// Purpose  : Shared types and constants for the dual-channel DAC SPI arbiter.
//            Holds the FSM state encoding, the DAC command-frame bit positions
//            and a helper that assembles a 16-bit command word.
// Revision : 1.0  initial release
// ============================================================================
package dac_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CSH   = 3'd3,
        ST_LDP   = 3'd4
    } state_t;

    localparam int DAC_BITS   = 10;
    localparam int FRAME_BITS = 16;

    // Command-word bit positions of an MCP4912-class DAC
    localparam int CH_POS     = 15;
    localparam int BUF_POS    = 14;
    localparam int GA_N_POS   = 13;
    localparam int SHDN_N_POS = 12;
    localparam int DATA_LSB   = 2;

    // Buffered reference, 1x gain, output active; low two bits unused
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic ch,
                                                          input logic [DAC_BITS-1:0] sample);
        logic [FRAME_BITS-1:0] f;
        f                        = '0;
        f[CH_POS]                = ch;
        f[BUF_POS]               = 1'b1;
        f[GA_N_POS]              = 1'b1;
        f[SHDN_N_POS]            = 1'b1;
        f[DATA_LSB +: DAC_BITS]  = sample;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_arbiter_if
// Purpose  : Bundles the two requester handshakes, the DAC pins and BUSY.
//            master = sample-source side, slave = arbiter side.
// Revision : 1.0  initial release
// ============================================================================
interface dac_spi_arbiter_if #(
    parameter int DATA_W = 10
);
    logic              REQ_A;
    logic [DATA_W-1:0] DATA_A;
    logic              ACK_A;
    logic              REQ_B;
    logic [DATA_W-1:0] DATA_B;
    logic              ACK_B;
    logic              DAC_CS;
    logic              DAC_SCK;
    logic              DAC_SDI;
    logic              DAC_LD;
    logic              BUSY;

    modport master (
        output REQ_A, DATA_A, REQ_B, DATA_B,
        input  ACK_A, ACK_B, DAC_CS, DAC_SCK, DAC_SDI, DAC_LD, BUSY
    );

    modport slave (
        input  REQ_A, DATA_A, REQ_B, DATA_B,
        output ACK_A, ACK_B, DAC_CS, DAC_SCK, DAC_SDI, DAC_LD, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/dac_spi_arbiter_sck_tick.sv
`default_nettype none
// ============================================================================
// Module   : dac_sck_tick
// Purpose  : SCK half-period timer. Down-counts SCK_DIV cycles and pulses
//            tick on the last cycle of each half-period. Held at reload while
//            clr is high so the first SHIFT half-period is a full one.
// Revision : 1.0  initial release
// ============================================================================
module dac_sck_tick #(
    parameter int SCK_DIV = 25
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      tick
);
    localparam int             CNT_W  = $clog2(SCK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on clear or terminal count, otherwise count down
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clr || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dac_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_arbiter
// Purpose  : Round-robin share of one dual-channel 10-bit SPI DAC between
//            requesters A and B. Builds the command frame, shifts it out MSB
//            first on SCK = CLOCK_50 / (2*SCK_DIV), then pulses LDAC.
//            Optional macro DAC_LD_SYNC_EN: LDAC only after both channels have
//            been written since the previous LDAC, so both outputs move
//            together.
// Revision : 1.0  initial release
// ============================================================================
module dac_spi_arbiter
    import dac_spi_pkg::*;
#(
    parameter int SCK_DIV = 25,
    parameter int DATA_W  = 10,
    parameter int FRAME_W = 16
) (
    input  wire logic        CLOCK_50,
    input  wire logic        RESET,
    dac_spi_arbiter_if.slave bus
);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

    if (DATA_W > DAC_BITS || DATA_W < 1) begin : g_bad_data_w
        $error("DATA_W must be in 1..10");
    end
    if (SCK_DIV < 2) begin : g_bad_sck_div
        $error("SCK_DIV must be at least 2");
    end
    if (FRAME_W != FRAME_BITS) begin : g_bad_frame_w
        $error("FRAME_W must be 16");
    end

    state_t                 state_q, state_d;
    logic                   last_q, last_d;      // 0 = A granted last, 1 = B
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [4:0]             bit_q, bit_d;        // bit currently on SDI
    logic                   half_q, half_d;      // 0 = SCK low half, 1 = high half
    logic                   cs_q, cs_d;
    logic                   sck_q, sck_d;
    logic                   sdi_q, sdi_d;
    logic                   ld_q, ld_d;
    logic                   ack_a_q, ack_a_d;
    logic                   ack_b_q, ack_b_d;
`ifdef DAC_LD_SYNC_EN
    logic [1:0]             written_q, written_d; // bit0 = A, bit1 = B
`endif

    logic                   tick;
    logic                   grant_b;
    logic [DAC_BITS-1:0]    sample_a;
    logic [DAC_BITS-1:0]    sample_b;

    // Narrow samples sit at the top of the DAC data field
    assign sample_a = DAC_BITS'(bus.DATA_A) << (DAC_BITS - DATA_W);
    assign sample_b = DAC_BITS'(bus.DATA_B) << (DAC_BITS - DATA_W);

    dac_sck_tick #(
        .SCK_DIV (SCK_DIV)
    ) u_tick (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .clr  ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
        .tick (tick)
    );

    // Arbitration, frame sequencing and registered pin values
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        half_d  = half_q;
        sdi_d   = sdi_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
`ifdef DAC_LD_SYNC_EN
        written_d = written_q;
`endif
        // With both requesting, the one not served last wins
        grant_b = (bus.REQ_A && bus.REQ_B) ? ~last_q : bus.REQ_B;

        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_A || bus.REQ_B) begin
                    state_d = ST_LOAD;
                    ack_a_d = ~grant_b;
                    ack_b_d = grant_b;
                    last_d  = grant_b;
                    shreg_d = build_frame(grant_b, grant_b ? sample_b : sample_a);
                    bit_d   = LAST_BIT;
                    half_d  = 1'b0;
`ifdef DAC_LD_SYNC_EN
                    written_d = written_q | {grant_b, ~grant_b};
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                sdi_d   = shreg_q[FRAME_BITS-1];
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (bit_q == 5'd0) begin
                        state_d = ST_CSH;
                    end else begin
                        half_d  = 1'b0;
                        bit_d   = bit_q - 5'd1;
                        shreg_d = shreg_q << 1;
                        sdi_d   = shreg_q[FRAME_BITS-2];
                    end
                end
            end
            ST_CSH: begin
                if (tick) begin
`ifdef DAC_LD_SYNC_EN
                    if (&written_q) begin
                        state_d   = ST_LDP;
                        written_d = 2'b00;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_LDP;
`endif
                end
            end
            ST_LDP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cs_d  = (state_d != ST_SHIFT);
        sck_d = (state_d == ST_SHIFT) && half_d;
        ld_d  = (state_d != ST_LDP);
        if (state_d == ST_IDLE) begin
            sdi_d = 1'b0;
        end
    end

    // State and pin registers; reset abandons any frame in flight
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            shreg_q <= '0;
            bit_q   <= 5'd0;
            half_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            ld_q    <= 1'b1;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
`ifdef DAC_LD_SYNC_EN
            written_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            ld_q    <= ld_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
`ifdef DAC_LD_SYNC_EN
            written_q <= written_d;
`endif
        end
    end

    assign bus.ACK_A   = ack_a_q;
    assign bus.ACK_B   = ack_b_q;
    assign bus.DAC_CS  = cs_q;
    assign bus.DAC_SCK = sck_q;
    assign bus.DAC_SDI = sdi_q;
    assign bus.DAC_LD  = ld_q;
    assign bus.BUSY    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_arbiter
// Purpose  : Self-checking bench for dac_spi_arbiter: pin-level frame capture,
//            a vector table, directed corner sequences and a randomized
//            two-requester run against a transaction-level arbitration model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_spi_arbiter;

    localparam int SCK_DIV = 25;
    localparam int DATA_W  = 10;
    localparam int FRAME_W = 16;
    localparam int TXN     = 1 + 34 * SCK_DIV;   // cycles per transaction
    localparam int NRAND   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    dac_spi_arbiter_if #(.DATA_W(DATA_W)) bus ();

    dac_spi_arbiter #(
        .SCK_DIV (SCK_DIV),
        .DATA_W  (DATA_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- pin monitor (samples on falling clock edge) ----------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ack_ch_q[$], ack_cyc_q[$], fr_q[$], bits_q[$], cs_len_q[$], ld_len_q[$];
    logic [15:0] cap = '0;
    int nbits = 0, cs_len = 0, ld_len = 0;
    logic sck_p = 1'b0, cs_p = 1'b1, ld_p = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            cap = '0; nbits = 0; cs_len = 0; ld_len = 0;
            sck_p = 1'b0; cs_p = 1'b1; ld_p = 1'b1;
        end else begin
            if (bus.ACK_A) begin ack_ch_q.push_back(0); ack_cyc_q.push_back(cyc); end
            if (bus.ACK_B) begin ack_ch_q.push_back(1); ack_cyc_q.push_back(cyc); end
            if (!bus.DAC_CS) begin
                cs_len++;
                if (bus.DAC_SCK && !sck_p) begin
                    cap = {cap[14:0], bus.DAC_SDI};
                    nbits++;
                end
            end
            if (bus.DAC_CS && !cs_p) begin
                fr_q.push_back(int'(cap)); bits_q.push_back(nbits); cs_len_q.push_back(cs_len);
                cap = '0; nbits = 0; cs_len = 0;
            end
            if (!bus.DAC_LD) ld_len++;
            if (bus.DAC_LD && !ld_p) begin ld_len_q.push_back(ld_len); ld_len = 0; end
            sck_p = bus.DAC_SCK; cs_p = bus.DAC_CS; ld_p = bus.DAC_LD;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ack_ch_q.delete(); ack_cyc_q.delete(); fr_q.delete();
        bits_q.delete(); cs_len_q.delete(); ld_len_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        clear_mon();
    endtask

    task automatic wait_acks(input int n, input int bound, input string name);
        for (int i = 0; i < bound && ack_ch_q.size() < n; i++) tick();
        check(name, ack_ch_q.size(), n);
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound && bus.BUSY; i++) tick();
        check(name, int'(bus.BUSY), 0);
    endtask

    function automatic int exp_frame(input int ch, input int data);
        return ch * 32768 + 28672 + (data % 1024) * 4;
    endfunction

    // ---------------- vector table ----------------------------------------
    typedef struct {
        bit   ra;
        bit   rb;
        int   da;
        int   db;
        int   ch;
        int   frame;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #1_900_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
        bus.DATA_A = '0;  bus.DATA_B = '0;

        tbl[0] = '{1'b1, 1'b0, 'h3FF, 'h000, 0, 'h7FFC};
        tbl[1] = '{1'b0, 1'b1, 'h000, 'h155, 1, 'hF554};
        tbl[2] = '{1'b1, 1'b1, 'h000, 'h2AA, 0, 'h7000};
        tbl[3] = '{1'b1, 1'b1, 'h155, 'h3FF, 1, 'hFFFC};
        tbl[4] = '{1'b1, 1'b1, 'h2AA, 'h000, 0, 'h7AA8};
        tbl[5] = '{1'b0, 1'b1, 'h000, 'h001, 1, 'hF004};
        tbl[6] = '{1'b1, 1'b1, 'h3FF, 'h155, 0, 'h7FFC};
        tbl[7] = '{1'b1, 1'b0, 'h200, 'h000, 0, 'h7800};

        // Reset values while reset is held
        repeat (2) tick();
        check("rst_cs",   int'(bus.DAC_CS),  1);
        check("rst_sck",  int'(bus.DAC_SCK), 0);
        check("rst_sdi",  int'(bus.DAC_SDI), 0);
        check("rst_ld",   int'(bus.DAC_LD),  1);
        check("rst_acka", int'(bus.ACK_A),   0);
        check("rst_ackb", int'(bus.ACK_B),   0);
        check("rst_busy", int'(bus.BUSY),    0);
        rst = 1'b0;
        tick();
        clear_mon();

        // Table: one transaction per entry; the loser drops REQ before any ACK
        for (int i = 0; i < 8; i++) begin
            int c0;
            bus.REQ_A = tbl[i].ra; bus.REQ_B = tbl[i].rb;
            bus.DATA_A = DATA_W'(tbl[i].da); bus.DATA_B = DATA_W'(tbl[i].db);
            c0 = cyc;
            wait_acks(1, 10, $sformatf("tbl%0d_ack", i));
            if (ack_ch_q.size() > 0) begin
                check($sformatf("tbl%0d_ch", i), ack_ch_q[0], tbl[i].ch);
                check($sformatf("tbl%0d_lat", i), ack_cyc_q[0], c0 + 1);
            end
            bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
            wait_idle(TXN + 10, $sformatf("tbl%0d_idle", i));
            repeat (3) tick();
            check($sformatf("tbl%0d_nack", i), ack_ch_q.size(), 1);
            check($sformatf("tbl%0d_nfr", i), fr_q.size(), 1);
            if (fr_q.size() > 0) begin
                check($sformatf("tbl%0d_frame", i), fr_q[0], tbl[i].frame);
                check($sformatf("tbl%0d_bits", i), bits_q[0], 16);
                check($sformatf("tbl%0d_cslen", i), cs_len_q[0], 32 * SCK_DIV);
            end
`ifndef DAC_LD_SYNC_EN
            check($sformatf("tbl%0d_nld", i), ld_len_q.size(), 1);
            if (ld_len_q.size() > 0)
                check($sformatf("tbl%0d_ldlen", i), ld_len_q[0], SCK_DIV);
`endif
            clear_mon();
        end

        // Both held high from reset: strict alternation, 852-cycle spacing
        do_reset();
        bus.DATA_A = 10'h3FF; bus.DATA_B = 10'h155;
        bus.REQ_A = 1'b1; bus.REQ_B = 1'b1;
        wait_acks(4, 4 * (TXN + 1) + 20, "alt_acks");
        bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
        wait_idle(TXN + 10, "alt_idle");
        repeat (2) tick();
        for (int k = 0; k < 4 && k < ack_ch_q.size(); k++) begin
            check($sformatf("alt_ch%0d", k), ack_ch_q[k], k % 2);
            if (k > 0) check($sformatf("alt_gap%0d", k), ack_cyc_q[k] - ack_cyc_q[k-1], TXN + 1);
            if (k < fr_q.size()) check($sformatf("alt_fr%0d", k), fr_q[k], (k % 2) ? 'hF554 : 'h7FFC);
        end
        clear_mon();

        // Reset during bit 7 of SHIFT, then a clean B frame
        bus.DATA_A = 10'h0F0; bus.REQ_A = 1'b1;
        wait_acks(1, 10, "mid_ack");
        bus.REQ_A = 1'b0;
        repeat (1 + 8 * 2 * SCK_DIV + 5) tick();
        check("mid_cs_before", int'(bus.DAC_CS), 0);
        rst = 1'b1;
        #1;
        check("mid_cs",   int'(bus.DAC_CS),  1);
        check("mid_sck",  int'(bus.DAC_SCK), 0);
        check("mid_ld",   int'(bus.DAC_LD),  1);
        check("mid_busy", int'(bus.BUSY),    0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_mon();
        bus.DATA_B = 10'h0AA; bus.REQ_B = 1'b1;
        wait_acks(1, 10, "post_ack");
        bus.REQ_B = 1'b0;
        wait_idle(TXN + 10, "post_idle");
        repeat (2) tick();
        if (ack_ch_q.size() > 0) check("post_ch", ack_ch_q[0], 1);
        check("post_nfr", fr_q.size(), 1);
        if (fr_q.size() > 0) begin
            check("post_frame", fr_q[0], 'hF2A8);
            check("post_bits", bits_q[0], 16);
        end
        clear_mon();

        // REQ_B raised 100 cycles into an A frame waits for IDLE
        bus.DATA_A = 10'h111; bus.REQ_A = 1'b1;
        wait_acks(1, 10, "late_acka");
        bus.REQ_A = 1'b0;
        repeat (100) tick();
        bus.DATA_B = 10'h3C3; bus.REQ_B = 1'b1;
        wait_acks(2, TXN + 20, "late_ackb");
        bus.REQ_B = 1'b0;
        if (ack_ch_q.size() >= 2) begin
            check("late_chb", ack_ch_q[1], 1);
            check("late_gap", ack_cyc_q[1] - ack_cyc_q[0], TXN + 1);
        end
        wait_idle(TXN + 10, "late_idle");
        repeat (2) tick();
        if (fr_q.size() >= 2) check("late_frb", fr_q[1], exp_frame(1, 'h3C3));
        clear_mon();

        // One-cycle REQ_A pulse while BUSY is ignored
        bus.DATA_A = 10'h123; bus.REQ_A = 1'b1;
        wait_acks(1, 10, "pulse_ack");
        bus.REQ_A = 1'b0;
        repeat (200) tick();
        bus.REQ_A = 1'b1;
        tick();
        bus.REQ_A = 1'b0;
        wait_idle(TXN + 10, "pulse_idle");
        repeat (20) tick();
        check("pulse_nack", ack_ch_q.size(), 1);
        check("pulse_nfr", fr_q.size(), 1);
        if (fr_q.size() > 0) check("pulse_frame", fr_q[0], 'h748C);
        clear_mon();

`ifdef DAC_LD_SYNC_EN
        // Paired update: LDAC only once both channels are written
        do_reset();
        bus.DATA_A = 10'h010; bus.REQ_A = 1'b1;
        wait_acks(1, 10, "sync_acka");
        bus.REQ_A = 1'b0;
        wait_idle(TXN + 10, "sync_idlea");
        repeat (2) tick();
        check("sync_noldA", ld_len_q.size(), 0);
        bus.DATA_B = 10'h020; bus.REQ_B = 1'b1;
        wait_acks(2, 10, "sync_ackb");
        bus.REQ_B = 1'b0;
        wait_idle(TXN + 10, "sync_idleb");
        repeat (2) tick();
        check("sync_ldB", ld_len_q.size(), 1);
        clear_mon();
`endif

        // Randomized requesters against a transaction-level model
        do_reset();
        begin
            int arr_a[$], dat_a[$], arr_b[$], dat_b[$];
            int ia, ib, free_at, last, ta, tb, t, k, ech, edat;
            bit pick_a;
            fork
                begin : drv_a
                    for (int i = 0; i < NRAND; i++) begin
                        automatic int d = int'($urandom_range(0, 1023));
                        automatic int w = 0;
                        repeat ($urandom_range(1, 1200)) tick();
                        bus.DATA_A = DATA_W'(d); bus.REQ_A = 1'b1;
                        arr_a.push_back(cyc + 1); dat_a.push_back(d);
                        while (!bus.ACK_A && w < 3000) begin tick(); w++; end
                        if (w >= 3000) begin
                            checks++; errors++;
                            $display("FAIL rnd_acka_timeout actual=none required=ACK_A");
                        end
                        bus.REQ_A = 1'b0;
                    end
                end
                begin : drv_b
                    for (int i = 0; i < NRAND; i++) begin
                        automatic int d = int'($urandom_range(0, 1023));
                        automatic int w = 0;
                        repeat ($urandom_range(1, 1200)) tick();
                        bus.DATA_B = DATA_W'(d); bus.REQ_B = 1'b1;
                        arr_b.push_back(cyc + 1); dat_b.push_back(d);
                        while (!bus.ACK_B && w < 3000) begin tick(); w++; end
                        if (w >= 3000) begin
                            checks++; errors++;
                            $display("FAIL rnd_ackb_timeout actual=none required=ACK_B");
                        end
                        bus.REQ_B = 1'b0;
                    end
                end
            join
            wait_idle(TXN + 10, "rnd_idle");
            repeat (2) tick();
            check("rnd_nack", ack_ch_q.size(), 2 * NRAND);
            check("rnd_nfr", fr_q.size(), 2 * NRAND);
            ia = 0; ib = 0; free_at = 0; last = 1; k = 0;
            while (ia < NRAND || ib < NRAND) begin
                ta = (ia < NRAND) ? arr_a[ia] : 32'h7FFF_FFFF;
                tb = (ib < NRAND) ? arr_b[ib] : 32'h7FFF_FFFF;
                t  = (ta < tb) ? ta : tb;
                if (free_at > t) t = free_at;
                pick_a = (ta <= t) && ((tb > t) || (last == 1));
                ech  = pick_a ? 0 : 1;
                edat = pick_a ? dat_a[ia] : dat_b[ib];
                if (k < ack_ch_q.size()) begin
                    check($sformatf("rnd%0d_ch", k), ack_ch_q[k], ech);
                    check($sformatf("rnd%0d_cyc", k), ack_cyc_q[k], t);
                end
                if (k < fr_q.size())
                    check($sformatf("rnd%0d_frame", k), fr_q[k], exp_frame(ech, edat));
                if (pick_a) ia++; else ib++;
                last    = ech;
                free_at = t + TXN + 1;
                k++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
